acq_vp_ram_responder: RTL and testbench

//  Responder end of the acquisition-RAM memory viewport: serves 16-bit viewport reads/writes issued by
//  the register-bus decoder against an internal single-port acquisition RAM, which is shared with the

---
 rtl/acq_vp_ram_responder_if.sv | 20 ++
 rtl/acq_vp_ram_responder.sv | 132 +++++++++++++
 tb/tb_acq_vp_ram_responder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/acq_vp_ram_responder_if.sv
// Viewport bus between the register-bus decoder (master) and the acquisition-RAM responder (slave).
interface acq_vp_ram_responder_if;
    logic [16:1] VMEAddr;
    logic [15:0] VMEWrData;
    logic        VMERdMem;
    logic        VMEWrMem;
    logic [15:0] VMERdData;
    logic        VMERdDone;
    logic        VMEWrDone;

    modport master (
        output VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
        input  VMERdData, VMERdDone, VMEWrDone
    );

    modport slave (
        input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
        output VMERdData, VMERdDone, VMEWrDone
    );
endinterface

// File: rtl/acq_vp_ram_responder.sv
// Viewport responder sharing a single-port acquisition RAM with a circular sample writer.
// Define ACQ_VP_RDPIPE_EN to add an output register after the RAM (one extra read cycle).
module acq_vp_ram_responder #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic                  Clk,
    input  logic                  Rst,
    acq_vp_ram_responder_if.slave vp,
    input  logic                  acq_wr_i,
    input  logic [15:0]           acq_dat_i,
    input  logic                  acq_arm_i,
    output logic [ADDR_W-1:0]     acq_ptr_o,
    output logic                  acq_wrapped_o,
    output logic                  vp_err_o
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_PEND,
        S_RD_PIPE,
        S_RD_DATA,
        S_WR_PEND,
        S_WR_ACK
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_mem [0:DEPTH-1];
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_wdata;
    logic [15:0]         r_rd_data;
    logic [ADDR_W-1:0]   r_ptr;
    logic                r_wrapped;
    logic                r_err;
    logic                w_strobe;
    logic                w_vp_re;
    logic                w_vp_we;
    logic                w_unused_addr;
`ifdef ACQ_VP_RDPIPE_EN
    logic [15:0]         r_ram_q;
`endif

    assign w_strobe      = vp.VMERdMem | vp.VMEWrMem;
    assign w_unused_addr = ^vp.VMEAddr;

    always_comb begin
        w_next  = r_state;
        w_vp_re = 1'b0;
        w_vp_we = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Write takes priority when both strobes arrive together.
                if (vp.VMEWrMem)      w_next = S_WR_PEND;
                else if (vp.VMERdMem) w_next = S_RD_PEND;
            end
            S_RD_PEND: begin
                if (!acq_wr_i) begin
                    w_vp_re = 1'b1;
`ifdef ACQ_VP_RDPIPE_EN
                    w_next  = S_RD_PIPE;
`else
                    w_next  = S_RD_DATA;
`endif
                end
            end
            S_RD_PIPE: w_next = S_RD_DATA;
            S_RD_DATA: w_next = S_IDLE;
            S_WR_PEND: begin
                if (!acq_wr_i) begin
                    w_vp_we = 1'b1;
                    w_next  = S_WR_ACK;
                end
            end
            S_WR_ACK:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd_data <= '0;
            r_err     <= 1'b0;
`ifdef ACQ_VP_RDPIPE_EN
            r_ram_q   <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_strobe) begin
                r_addr  <= vp.VMEAddr[ADDR_W:1];
                r_wdata <= vp.VMEWrData;
            end
            if ((r_state != S_IDLE && w_strobe) || (vp.VMERdMem && vp.VMEWrMem))
                r_err <= 1'b1;
`ifdef ACQ_VP_RDPIPE_EN
            if (w_vp_re)              r_ram_q   <= r_mem[r_addr];
            if (r_state == S_RD_PIPE) r_rd_data <= r_ram_q;
`else
            if (w_vp_re)              r_rd_data <= r_mem[r_addr];
`endif
        end
    end

    // Single RAM port: an acquisition write owns the slot, viewport writes only use free slots.
    always_ff @(posedge Clk) begin
        if (acq_wr_i)     r_mem[r_ptr]  <= acq_dat_i;
        else if (w_vp_we) r_mem[r_addr] <= r_wdata;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_ptr     <= '0;
            r_wrapped <= 1'b0;
        end else if (acq_arm_i) begin
            r_ptr     <= '0;
            r_wrapped <= 1'b0;
        end else if (acq_wr_i) begin
            r_ptr <= r_ptr + ADDR_W'(1);
            if (r_ptr == '1) r_wrapped <= 1'b1;
        end
    end

    assign vp.VMERdData  = r_rd_data;
    assign vp.VMERdDone  = (r_state == S_RD_DATA);
    assign vp.VMEWrDone  = (r_state == S_WR_ACK);
    assign acq_ptr_o     = r_ptr;
    assign acq_wrapped_o = r_wrapped;
    assign vp_err_o      = r_err;
endmodule

// File: tb/tb_acq_vp_ram_responder.sv
// Bench: two responders (ADDR_W=10 and ADDR_W=4) driven in lockstep against a memory/pointer model.
module tb_acq_vp_ram_responder;
`ifdef ACQ_VP_RDPIPE_EN
    localparam int RDX = 1;
`else
    localparam int RDX = 0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] addr, wdata;
    logic        rd, wr;
    logic        acq_wr, acq_arm;
    logic [15:0] acq_dat;
    logic [9:0]  ptr_big;
    logic [3:0]  ptr_small;
    logic        wrap_big, wrap_small, err_big, err_small;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m10 [0:1023];
    bit          v10 [0:1023];
    logic [15:0] m4  [0:15];
    bit          v4  [0:15];
    int unsigned p10, p4;
    bit          w10, w4, err_exp;

    acq_vp_ram_responder_if if10 ();
    acq_vp_ram_responder_if if4 ();

    assign if10.VMEAddr = addr;  assign if4.VMEAddr = addr;
    assign if10.VMEWrData = wdata; assign if4.VMEWrData = wdata;
    assign if10.VMERdMem = rd;   assign if4.VMERdMem = rd;
    assign if10.VMEWrMem = wr;   assign if4.VMEWrMem = wr;

    acq_vp_ram_responder #(.ADDR_W(10)) u_big (
        .Clk(clk), .Rst(rst), .vp(if10),
        .acq_wr_i(acq_wr), .acq_dat_i(acq_dat), .acq_arm_i(acq_arm),
        .acq_ptr_o(ptr_big), .acq_wrapped_o(wrap_big), .vp_err_o(err_big)
    );

    acq_vp_ram_responder #(.ADDR_W(4)) u_small (
        .Clk(clk), .Rst(rst), .vp(if4),
        .acq_wr_i(acq_wr), .acq_dat_i(acq_dat), .acq_arm_i(acq_arm),
        .acq_ptr_o(ptr_small), .acq_wrapped_o(wrap_small), .vp_err_o(err_small)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_ptr_big"},    32'(ptr_big),    32'(p10));
        chk({tag, "_ptr_small"},  32'(ptr_small),  32'(p4));
        chk({tag, "_wrap"},       {wrap_big, wrap_small}, {w10, w4});
        chk({tag, "_err"},        {err_big, err_small},   {2{err_exp}});
    endtask

    task automatic model_acq(input logic w, input logic arm, input logic [15:0] dd);
        if (w) begin
            m10[p10] = dd; v10[p10] = 1'b1;
            m4[p4]   = dd; v4[p4]   = 1'b1;
        end
        if (arm) begin
            p10 = 0; p4 = 0; w10 = 1'b0; w4 = 1'b0;
        end else if (w) begin
            if (p10 == 1023) w10 = 1'b1;
            if (p4 == 15)    w4  = 1'b1;
            p10 = (p10 + 1) % 1024;
            p4  = (p4 + 1) % 16;
        end
    endtask

    // kind: 0 read, 1 write, 2 read+write together. pat[i] = acq write in strobe cycle + i.
    task automatic run_op(input int kind, input logic [15:0] a, input logic [15:0] d,
                          input logic [7:0] pat, input int err_at);
        int          s, dl;
        int unsigned i10, i4;
        logic [15:0] e10, e4;
        bit          ok10, ok4;
        i10 = a % 1024;
        i4  = a % 16;
        s = 1;
        while (s < 8 && pat[s]) s++;
        dl = s + 1 + ((kind == 0) ? RDX : 0);
        e10 = '0; e4 = '0; ok10 = 1'b0; ok4 = 1'b0;
        for (int i = 0; i <= dl + 1; i++) begin
            @(negedge clk);
            chk("rd_done", {if10.VMERdDone, if4.VMERdDone}, {2{kind == 0 && i == dl}});
            chk("wr_done", {if10.VMEWrDone, if4.VMEWrDone}, {2{kind != 0 && i == dl}});
            if (kind == 0 && i >= dl) begin
                if (ok10) chk("rd_data_big", 32'(if10.VMERdData), 32'(e10));
                if (ok4)  chk("rd_data_small", 32'(if4.VMERdData), 32'(e4));
            end
            if (i == dl + 1) chk_status("op_end");
            if (i == s) begin
                if (kind == 0) begin
                    e10 = m10[i10]; ok10 = v10[i10];
                    e4  = m4[i4];   ok4  = v4[i4];
                end else begin
                    m10[i10] = d; v10[i10] = 1'b1;
                    m4[i4]   = d; v4[i4]   = 1'b1;
                end
            end
            rd = ((i == 0) && kind != 1) || (err_at > 0 && i == err_at);
            wr = (i == 0) && kind != 0;
            if ((i == 0 && kind == 2) || (err_at > 0 && i == err_at)) err_exp = 1'b1;
            addr    = (i == 0) ? a : 16'($urandom);
            wdata   = (i == 0) ? d : 16'($urandom);
            acq_wr  = (i <= dl && i < 8) ? pat[i] : 1'b0;
            acq_dat = 16'($urandom);
            acq_arm = 1'b0;
            model_acq(acq_wr, 1'b0, acq_dat);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_data"}, {16'(if10.VMERdData), 16'(if4.VMERdData)}, '0);
        chk({tag, "_done"}, {if10.VMERdDone, if10.VMEWrDone, if4.VMERdDone, if4.VMEWrDone}, '0);
        chk({tag, "_ptr"}, {22'(ptr_big), 4'(ptr_small)}, '0);
        chk({tag, "_flags"}, {wrap_big, wrap_small, err_big, err_small}, '0);
    endtask

    initial begin
        rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        acq_wr = 1'b0; acq_arm = 1'b0; acq_dat = '0;
        p10 = 0; p4 = 0; w10 = 1'b0; w4 = 1'b0; err_exp = 1'b0;
        for (int k = 0; k < 1024; k++) v10[k] = 1'b0;
        for (int k = 0; k < 16; k++)   v4[k]  = 1'b0;

        // Reset and idle
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            chk("idle_done", {if10.VMERdDone, if10.VMEWrDone, if4.VMERdDone, if4.VMEWrDone}, '0);
        end

        // Write then read back, uncontended
        run_op(1, 16'h0005, 16'hBEEF, 8'h00, 0);
        run_op(0, 16'h0005, 16'h0000, 8'h00, 0);

        // Acquisition holds the port for four cycles across a read
        run_op(1, 16'h0010, 16'h5A5A, 8'h00, 0);
        run_op(0, 16'h0010, 16'h0000, 8'b0001_1110, 0);
        run_op(1, 16'h0033, 16'hC0DE, 8'b0000_0110, 0);

        // Read after an acquisition slot to the same address sees the new sample
        run_op(0, 16'(p10), 16'h0000, 8'b0000_0001, 0);
        run_op(0, 16'(p10 + 1), 16'h0000, 8'b0000_0011, 0);

        // Wraparound on the 16-word instance, then arm coincident with a sample
        @(negedge clk);
        acq_arm = 1'b1; model_acq(1'b0, 1'b1, 16'h0);
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            acq_arm = 1'b0; acq_wr = 1'b1; acq_dat = 16'(k);
            model_acq(1'b1, 1'b0, 16'(k));
        end
        @(negedge clk);
        acq_wr = 1'b0;
        chk("wrap_ptr_small", 32'(ptr_small), 32'd1);
        chk("wrap_flag_small", 32'(wrap_small), 32'd1);
        chk_status("wrap");
        run_op(0, 16'h0000, 16'h0000, 8'h00, 0);
        @(negedge clk);
        acq_arm = 1'b1; acq_wr = 1'b1; acq_dat = 16'h7777;
        model_acq(1'b1, 1'b1, 16'h7777);
        @(negedge clk);
        acq_arm = 1'b0; acq_wr = 1'b0;
        chk("arm_ptr", {22'(ptr_big), 4'(ptr_small)}, '0);
        chk("arm_flag", {wrap_big, wrap_small}, '0);
        run_op(0, 16'h0001, 16'h0000, 8'h00, 0);

        // Randomised traffic with random acquisition contention
        for (int k = 0; k < 40; k++) begin
            logic [15:0] ra;
            ra = (16'($urandom) & 16'hFC00) | 16'($urandom_range(0, 31));
            run_op(int'($urandom_range(0, 1)), ra, 16'($urandom), 8'($urandom & $urandom), 0);
        end

        // Protocol errors: strobe while busy, both strobes together
        chk("err_clear", {err_big, err_small}, 2'b00);
        run_op(0, 16'h0005, 16'h0000, 8'b0000_0110, 1);
        run_op(2, 16'h0044, 16'hA1B2, 8'h00, 0);
        run_op(0, 16'h0044, 16'h0000, 8'h00, 0);

        // Asynchronous reset while a write is pending
        run_op(1, 16'h0020, 16'h1234, 8'h00, 0);
        @(negedge clk);
        wr = 1'b1; addr = 16'h0020; wdata = 16'hDEAD;
        @(negedge clk);
        wr = 1'b0; addr = '0; wdata = '0;
        chk("wrpend_no_done", {if10.VMEWrDone, if4.VMEWrDone}, '0);
        #1 rst = 1'b1;
        #1 chk_reset_outputs("async_rst");
        p10 = 0; p4 = 0; w10 = 1'b0; w4 = 1'b0; err_exp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_done", {if10.VMERdDone, if10.VMEWrDone, if4.VMERdDone, if4.VMEWrDone}, '0);
        end
        run_op(0, 16'h0020, 16'h0000, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
